// File: rtl/soc_pkg.sv
// Shared SoC definitions: UART TX drain FSM encoding and the UART register
// offsets mem_ctl decodes into push, flush, ovf_clr and status reads.
package soc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

    typedef enum logic [3:0] {
        UART_REG_TXDATA = 4'h0,
        UART_REG_STATUS = 4'h4,
        UART_REG_FLUSH  = 4'h8,
        UART_REG_OVFCLR = 4'hC
    } uart_reg_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular register-array FIFO. The level counter is authoritative; full and
// empty decode from it. Flush drops everything queued and any same-cycle push.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_wr_en;
    logic              w_rd_en;

    assign full    = (r_level == (ADDR_W+1)'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_rd_en = pop && !empty && !flush;
    assign w_wr_en = push && !flush && (!full || w_rd_en);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART TX front-end: queues CPU byte writes and drains them one at a
// time to the serializer. Handshake: uart_tx_en is a one-cycle launch with uart_tx_data; uart_tx_busy high means the serializer took it.
module uart_tx_fifo
    import soc_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [7:0]      push_data,
    input  logic            flush,
    input  logic            ovf_clr,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] level,
    output logic            overflow,
    output logic            tx_idle,
    output logic            uart_tx_en,
    output logic [7:0]      uart_tx_data,
    input  logic            uart_tx_busy,
    output tx_state_e       dbg_state
);

    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    tx_state_e        r_state;
    logic             r_tx_en;
    logic [7:0]       r_tx_data;
    logic [TMR_W-1:0] r_timer;
    logic             r_overflow;
    logic             w_pop;
    logic             w_ovf_event;
    logic [7:0]       w_rd_data;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .WIDTH  (8),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (w_pop),
        .flush     (flush),
        .rd_data   (w_rd_data),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign w_pop       = (r_state == IDLE) && !empty && !uart_tx_busy && !flush;
    assign w_ovf_event = push && !flush && full && !w_pop;

    assign tx_idle      = empty && (r_state == IDLE);
    assign uart_tx_en   = r_tx_en;
    assign uart_tx_data = r_tx_data;
    assign overflow     = r_overflow;
    assign dbg_state    = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tx_en   <= 1'b0;
            r_tx_data <= 8'h00;
            r_timer   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= w_rd_data;
                        r_tx_en   <= 1'b1;
                        r_state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_tx_en <= 1'b0;
                    r_timer <= TMR_W'(BUSY_TIMEOUT);
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A serializer that never raises busy is assumed to have taken the byte.
                    if (uart_tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        if (r_timer <= TMR_W'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_event) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: status vector table plus directed drain sequences
// against a byte scoreboard and a simple serializer busy model.
module tb_uart_tx_fifo;
    import soc_pkg::*;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 4;
    localparam int NV           = 23;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            push;
    logic [7:0]      push_data;
    logic            flush;
    logic            ovf_clr;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] level;
    logic            overflow;
    logic            tx_idle;
    logic            uart_tx_en;
    logic [7:0]      uart_tx_data;
    logic            uart_tx_busy;
    tx_state_e       dbg_state;

    logic            man_busy;
    logic            model_busy;
    logic            model_on;
    logic            prev_en;
    int              frame_len;
    int              busy_cnt;
    int              launches;
    int              errors;
    int              checks;
    logic [7:0]      exp_q[$];

    typedef struct {
        logic            push;
        logic [7:0]      data;
        logic            flush;
        logic            ovf_clr;
        logic [ADDR_W:0] level;
        logic            full;
        logic            empty;
        logic            ovf;
        logic            idle;
    } vec_t;

    vec_t vecs[NV];

    assign uart_tx_busy = man_busy | model_busy;

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_data    (push_data),
        .flush        (flush),
        .ovf_clr      (ovf_clr),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .tx_idle      (tx_idle),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic p, input logic [7:0] d, input logic f, input logic c,
                                input int lv, input logic fu, input logic em, input logic ov,
                                input logic id);
        vec_t v;
        v.push = p; v.data = d; v.flush = f; v.ovf_clr = c;
        v.level = (ADDR_W+1)'(lv); v.full = fu; v.empty = em; v.ovf = ov; v.idle = id;
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (!(tx_idle && !uart_tx_busy) && n < max) begin
            cycle();
            n++;
        end
        chk(name, {31'b0, tx_idle && !uart_tx_busy}, 1);
    endtask

    // Serializer model and launch scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!model_on) busy_cnt = 0;
        else if (busy_cnt > 0) busy_cnt--;
        if (uart_tx_en) begin
            launches++;
            chk("en_single_cycle", {31'b0, prev_en}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL launch_unexpected: got %0h expected no launch", uart_tx_data);
            end else begin
                chk("launch_data", uart_tx_data, exp_q.pop_front());
            end
            if (model_on) busy_cnt = frame_len;
        end
        prev_en    = uart_tx_en;
        model_busy = (busy_cnt > 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int peak;
        logic full_seen;

        errors = 0; checks = 0; launches = 0; busy_cnt = 0;
        model_busy = 1'b0; model_on = 1'b0; frame_len = 0; prev_en = 1'b0;
        rst_n = 1'b0; push = 1'b0; push_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0;
        man_busy = 1'b1;

        vecs[0] = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            vecs[i] = mk(1, 8'(8'h10 + i), 0, 0, i, (i == 16), 0, 0, 0);
        end
        vecs[17] = mk(1, 8'h99, 0, 0, 16, 1, 0, 1, 0);
        vecs[18] = mk(0, 8'h00, 0, 0, 16, 1, 0, 1, 0);
        vecs[19] = mk(0, 8'h00, 0, 1, 16, 1, 0, 0, 0);
        vecs[20] = mk(1, 8'h98, 0, 1, 16, 1, 0, 1, 0);
        vecs[21] = mk(0, 8'h00, 0, 1, 16, 1, 0, 0, 0);
        vecs[22] = mk(1, 8'h97, 1, 0, 0, 0, 1, 0, 1);

        repeat (3) cycle();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_idle", tx_idle, 1);
        chk("rst_tx_en", uart_tx_en, 0);
        chk("rst_tx_data", uart_tx_data, 8'h00);
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;

        // Status table with the serializer held busy so nothing drains.
        for (int i = 0; i < NV; i++) begin
            push = vecs[i].push; push_data = vecs[i].data;
            flush = vecs[i].flush; ovf_clr = vecs[i].ovf_clr;
            cycle();
            chk($sformatf("vec%0d_level", i), level, vecs[i].level);
            chk($sformatf("vec%0d_full", i), full, vecs[i].full);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
            chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
            chk($sformatf("vec%0d_tx_idle", i), tx_idle, vecs[i].idle);
        end
        push = 1'b0; flush = 1'b0; ovf_clr = 1'b0; man_busy = 1'b0;

        // Single byte.
        model_on = 1'b1; frame_len = 5;
        exp_q.push_back(8'h41);
        push = 1'b1; push_data = 8'h41;
        cycle();
        push = 1'b0;
        chk("single_no_early_en", uart_tx_en, 0);
        chk("single_level1", level, 1);
        cycle();
        chk("single_en", uart_tx_en, 1);
        chk("single_data", uart_tx_data, 8'h41);
        chk("single_not_idle", tx_idle, 0);
        wait_idle(40, "single_idle");
        chk("single_state_idle", dbg_state, IDLE);

        // Burst of 16 with 20-cycle frames.
        frame_len = 20; full_seen = 1'b0; peak = 0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            push = 1'b1; push_data = 8'(i);
            cycle();
            if (full) full_seen = 1'b1;
            if (int'(level) > peak) peak = int'(level);
        end
        push = 1'b0;
        chk("burst_no_full", {31'b0, full_seen}, 0);
        chk("burst_peak_level", peak, 15);
        wait_idle(1000, "burst_idle");
        chk("burst_drained", exp_q.size(), 0);

        // Wrap-around: fill, drain 10, push 8 more.
        man_busy = 1'b1; frame_len = 3;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'hB0 + i));
            push = 1'b1; push_data = 8'(8'hB0 + i);
            cycle();
        end
        push = 1'b0;
        chk("wrap_full", full, 1);
        chk("wrap_level16", level, 16);
        base = launches; man_busy = 1'b0; n = 0;
        while (launches < base + 10 && n < 500) begin
            cycle();
            n++;
        end
        chk("wrap_drain10", {31'b0, launches >= base + 10}, 1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'hC0 + i));
            push = 1'b1; push_data = 8'(8'hC0 + i);
            cycle();
        end
        push = 1'b0;
        wait_idle(1000, "wrap_idle");
        chk("wrap_drained", exp_q.size(), 0);
        chk("wrap_empty", empty, 1);
        chk("wrap_level0", level, 0);

        // Flush with one byte in flight.
        frame_len = 40; base = launches;
        exp_q.push_back(8'hD0);
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 8'(8'hD0 + i);
            cycle();
        end
        push = 1'b0;
        chk("flush_pre_level", level, 4);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_level0", level, 0);
        chk("flush_empty", empty, 1);
        chk("flush_inflight_busy", tx_idle, 0);
        wait_idle(100, "flush_idle");
        chk("flush_one_launch", launches - base, 1);
        push = 1'b1; push_data = 8'hEE; flush = 1'b1;
        cycle();
        push = 1'b0; flush = 1'b0;
        chk("flushpush_level0", level, 0);
        chk("flushpush_overflow", overflow, 0);
        repeat (5) cycle();
        chk("flushpush_no_launch", launches - base, 1);

        // Timeout: serializer never raises busy.
        model_on = 1'b0;
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        push = 1'b1; push_data = 8'hE1;
        cycle();
        push_data = 8'hE2;
        cycle();
        push = 1'b0;
        chk("timeout_first_en", uart_tx_en, 1);
        chk("timeout_first_data", uart_tx_data, 8'hE1);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!uart_tx_en && n < 20);
        chk("timeout_gap", n, 6);
        chk("timeout_second_data", uart_tx_data, 8'hE2);
        wait_idle(20, "timeout_idle");
        chk("timeout_data_held", uart_tx_data, 8'hE2);

        // Asynchronous reset while waiting on the frame.
        model_on = 1'b1; frame_len = 30; base = launches;
        exp_q.push_back(8'hF0);
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = 8'(8'hF0 + i);
            cycle();
        end
        push = 1'b0;
        n = 0;
        while (dbg_state != WAIT_DONE && n < 20) begin
            cycle();
            n++;
        end
        chk("rst2_reached_wait_done", dbg_state, WAIT_DONE);
        rst_n = 1'b0;
        #1;
        chk("rst2_level", level, 0);
        chk("rst2_empty", empty, 1);
        chk("rst2_full", full, 0);
        chk("rst2_overflow", overflow, 0);
        chk("rst2_tx_idle", tx_idle, 1);
        chk("rst2_tx_en", uart_tx_en, 0);
        chk("rst2_tx_data", uart_tx_data, 8'h00);
        chk("rst2_state", dbg_state, IDLE);
        model_on = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        chk("rst2_no_launch", launches - base, 1);
        chk("rst2_empty_after", empty, 1);

        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
